// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receive FSM state encoding
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int SAMPLE_RATE = 16;
  localparam int CLK_HZ      = 50_000_000;
  localparam int BAUD_RATE   = 115_200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// rtl/uart_rx_deserializer_if.sv - received-byte handshake and error-flag bundle
// Optional: UART_RX_PARITY_EN adds parity_error.
// master (deserializer): drives rx_data, rx_data_valid, framing_error, overrun[, parity_error]; samples rx_data_read
// slave  (consumer):     the reverse
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_valid;
  logic                 rx_data_read;
  logic                 framing_error;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_error;

  modport master (
    output rx_data, rx_data_valid, framing_error, overrun, parity_error,
    input  rx_data_read
  );
  modport slave (
    input  rx_data, rx_data_valid, framing_error, overrun, parity_error,
    output rx_data_read
  );
`else
  modport master (
    output rx_data, rx_data_valid, framing_error, overrun,
    input  rx_data_read
  );
  modport slave (
    input  rx_data, rx_data_valid, framing_error, overrun,
    output rx_data_read
  );
`endif
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with configurable reset value
// Ports: clock, reset_n (async active-low), d_i (asynchronous input), q_o (synchronised output)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - oversampled UART receiver, LSB-first, byte register with valid/read handshake
// Optional: UART_RX_PARITY_EN inserts an even-parity bit between data and stop.
// Ports: clock, reset_n (async active-low), rx (async serial line, idle high), tick (oversample strobe),
//        start_rx (start-edge pulse to the baud generator), rx_if (uart_rx_deserializer_if.master)
module uart_rx_deserializer #(
  parameter int SAMPLE_RATE = uart_pkg::SAMPLE_RATE,
  parameter int DATA_BITS   = uart_pkg::DATA_BITS
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rx,
  input  logic tick,
  output logic start_rx,
  uart_rx_deserializer_if.master rx_if
);
  import uart_pkg::*;

  localparam int TW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_STOP   = STOP;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = PARITY;
`endif

  localparam logic [TW-1:0] HALF_M1  = TW'(SAMPLE_RATE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 fe_q, fe_d;
  logic                 fall;
  logic                 wrap;
  logic                 parity_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 pe_q, pe_d;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (rx),
    .q_o     (rx_s)
  );

  assign fall = rx_prev_q & ~rx_s;
  // Sampling point of every data/parity/stop bit: the tick that wraps the counter.
  assign wrap = tick && (tick_cnt_q == FULL_M1);

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_bad = ^{shift_q, par_q};
`else
  assign parity_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    fe_d       = 1'b0;
    start_rx   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    pe_d       = 1'b0;
`endif

    if (rx_if.rx_data_read) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          start_rx   = 1'b1;
          tick_cnt_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_M1) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = S_DATA;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (wrap) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (wrap) begin
            par_d   = rx_s;
            state_d = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (wrap) begin
            state_d = S_IDLE;
            if (!rx_s) fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (parity_bad) pe_d = 1'b1;
`endif
            if (rx_s && !parity_bad) begin
              data_d    = shift_q;
              valid_d   = 1'b1;
              // A read in the same cycle consumed the old byte, so nothing was lost.
              overrun_d = valid_q & ~rx_if.rx_data_read;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      fe_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      fe_q       <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      pe_q       <= pe_d;
`endif
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_data_valid = valid_q;
  assign rx_if.overrun       = overrun_q;
  assign rx_if.framing_error = fe_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_error  = pe_q;
`endif
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - self-checking bench for uart_rx_deserializer
module tb_uart_rx_deserializer;
  localparam int CPT     = 4;
  localparam int BIT_CYC = 16 * CPT;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic rx      = 1'b1;
  logic tick    = 1'b0;
  logic start_rx;

  uart_rx_deserializer_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_deserializer #(.SAMPLE_RATE(16), .DATA_BITS(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx       (rx),
    .tick     (tick),
    .start_rx (start_rx),
    .rx_if    (rx_if)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ovr   = 1'b0;
  int         exp_starts = 0, exp_fe = 0, exp_pe = 0;
  int         starts_seen = 0, fe_seen = 0, pe_seen = 0;
  logic       settled = 1'b0;
  logic       start_prev = 1'b0, fe_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Baud generator stand-in: tick every CPT cycles, re-phased on start_rx.
  initial begin
    int div = 0;
    forever begin
      @(negedge clock);
      if (start_rx) div = 0;
      else div = (div + 1) % CPT;
      tick = (div == CPT - 1);
    end
  end

  // Compare process: pulse bookkeeping every cycle, full state compare when the line is quiet.
  initial begin
    forever begin
      @(negedge clock);
      if (start_rx) begin
        starts_seen++;
        check("start_rx_width", {31'b0, start_prev}, 0);
      end
      if (rx_if.framing_error) begin
        fe_seen++;
        check("framing_error_width", {31'b0, fe_prev}, 0);
      end
`ifdef UART_RX_PARITY_EN
      if (rx_if.parity_error) pe_seen++;
`endif
      start_prev = start_rx;
      fe_prev    = rx_if.framing_error;
      if (settled) begin
        check("model_rx_data", {24'b0, rx_if.rx_data}, {24'b0, exp_data});
        check("model_valid", {31'b0, rx_if.rx_data_valid}, {31'b0, exp_valid});
        check("model_overrun", {31'b0, rx_if.overrun}, {31'b0, exp_ovr});
        check("model_start_count", starts_seen, exp_starts);
        check("model_fe_count", fe_seen, exp_fe);
`ifdef UART_RX_PARITY_EN
        check("model_pe_count", pe_seen, exp_pe);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CYC) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    settled = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  // Frame-level model: what a complete frame must do to the byte register and flags.
  task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    logic ok;
    exp_starts++;
    ok = stop_bit;
`ifdef UART_RX_PARITY_EN
    if (^{b, par_bit}) begin
      exp_pe++;
      ok = 1'b0;
    end
`endif
    if (!stop_bit) exp_fe++;
    if (ok) begin
      if (exp_valid) exp_ovr = 1'b1;
      exp_data  = b;
      exp_valid = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    send_frame(b, stop_bit, par_bit);
    model_frame(b, stop_bit, par_bit);
  endtask

  task automatic settle();
    repeat (4) @(negedge clock);
    settled = 1'b1;
    repeat (4) @(negedge clock);
    settled = 1'b0;
  endtask

  task automatic read_byte();
    rx_if.rx_data_read = 1'b1;
    @(negedge clock);
    rx_if.rx_data_read = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  initial begin
    rx_if.rx_data_read = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_rx_data", {24'b0, rx_if.rx_data}, 0);
    check("reset_valid", {31'b0, rx_if.rx_data_valid}, 0);
    check("reset_overrun", {31'b0, rx_if.overrun}, 0);
    check("reset_framing_error", {31'b0, rx_if.framing_error}, 0);
    check("reset_start_rx", {31'b0, start_rx}, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    settle();

    // 0xA5, clean frame
    frame(8'hA5, 1'b1, 1'b0);
    settle();
    check("a5_data", {24'b0, rx_if.rx_data}, 32'hA5);
    check("a5_valid", {31'b0, rx_if.rx_data_valid}, 1);
    check("a5_overrun", {31'b0, rx_if.overrun}, 0);
    check("a5_starts", starts_seen, 1);
    check("a5_fe", fe_seen, 0);
    read_byte();

    // False start: 4 ticks low
    settled = 1'b0;
    rx = 1'b0;
    repeat (4 * CPT) @(negedge clock);
    rx = 1'b1;
    repeat (100) @(negedge clock);
    exp_starts++;
    settle();
    check("false_start_starts", starts_seen, 2);
    check("false_start_valid", {31'b0, rx_if.rx_data_valid}, 0);

    // 0x3C with stop bit low
    frame(8'h3C, 1'b0, 1'b0);
    repeat (BIT_CYC) @(negedge clock);
    settle();
    check("fe_count", fe_seen, 1);
    check("fe_valid", {31'b0, rx_if.rx_data_valid}, 0);
    check("fe_data_kept", {24'b0, rx_if.rx_data}, 32'hA5);

    // Back-to-back 0x11, 0x22 without read
    frame(8'h11, 1'b1, 1'b0);
    frame(8'h22, 1'b1, 1'b0);
    settle();
    check("b2b_data", {24'b0, rx_if.rx_data}, 32'h22);
    check("b2b_valid", {31'b0, rx_if.rx_data_valid}, 1);
    check("b2b_overrun", {31'b0, rx_if.overrun}, 1);
    read_byte();
    settle();
    check("read_valid", {31'b0, rx_if.rx_data_valid}, 0);
    check("read_overrun", {31'b0, rx_if.overrun}, 0);

    // Reset during bit 4 of 0xFF, then 0x5A
    settled = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (BIT_CYC / 2) @(negedge clock);
    reset_n = 1'b0;
    exp_starts++;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    settle();
    check("midreset_data", {24'b0, rx_if.rx_data}, 0);
    frame(8'h5A, 1'b1, 1'b0);
    settle();
    check("after_reset_data", {24'b0, rx_if.rx_data}, 32'h5A);
    check("after_reset_valid", {31'b0, rx_if.rx_data_valid}, 1);
    check("after_reset_overrun", {31'b0, rx_if.overrun}, 0);

`ifdef UART_RX_PARITY_EN
    read_byte();
    frame(8'h07, 1'b1, 1'b0);
    settle();
    check("par_bad_count", pe_seen, 1);
    check("par_bad_valid", {31'b0, rx_if.rx_data_valid}, 0);
    frame(8'h07, 1'b1, 1'b1);
    settle();
    check("par_ok_data", {24'b0, rx_if.rx_data}, 32'h07);
    check("par_ok_valid", {31'b0, rx_if.rx_data_valid}, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
